// File: rtl/muladd_dot_seq.sv
// muladd_dot_seq: sequencing controller for a signed 8x8 multiply-add
// datapath. Takes a dot-product job (length, bias), streams operand pairs
// through a registered multiply stage into an ACC_W-bit accumulator, and
// returns the sum over a valid/ready result port.
//
// Build option: define MULADD_DOT_SATURATE_EN to clamp the accumulator on
// overflow instead of letting it wrap modulo 2^ACC_W. In both builds the
// sticky ovf flag reports that an overflow happened during the job.
module muladd_dot_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 20
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [LEN_W-1:0]          r_cnt;
    logic                      r_ovf;

    // stage 1: latched operand pair
    logic signed [DATA_W-1:0]  r_a_p1;
    logic signed [DATA_W-1:0]  r_b_p1;
    logic                      r_vld_p1;

    // stage 2: accumulator
    logic signed [ACC_W-1:0]   r_acc_p2;

    logic                      w_accept;
    logic signed [PROD_W-1:0]  w_prod_p1;
    logic signed [ACC_W:0]     w_sum_p1;
    logic                      w_ovf_p1;
    logic signed [ACC_W-1:0]   w_next_acc_p1;

    // True overflow: the ACC_W+1-bit sum does not fit back into ACC_W bits.
    function automatic logic f_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

`ifdef MULADD_DOT_SATURATE_EN
    // Clamp to the most positive / most negative value on overflow; the
    // extra top bit of the wide sum carries the true sign.
    function automatic logic signed [ACC_W-1:0] f_sat(input logic signed [ACC_W:0] s);
        if (f_ovf(s)) begin
            if (s[ACC_W]) begin
                return {1'b1, {(ACC_W-1){1'b0}}};
            end
            return {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction
`endif

    assign w_accept  = (r_state == S_RUN) && in_valid;
    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_acc_p2;
    assign ovf       = r_ovf;

    // ---- stage 1 -> stage 2 boundary: product and wide sum ----
    assign w_prod_p1 = r_a_p1 * r_b_p1;
    assign w_sum_p1  = {r_acc_p2[ACC_W-1], r_acc_p2}
                     + {{(ACC_W+1-PROD_W){w_prod_p1[PROD_W-1]}}, w_prod_p1};
    assign w_ovf_p1  = f_ovf(w_sum_p1);

`ifdef MULADD_DOT_SATURATE_EN
    assign w_next_acc_p1 = f_sat(w_sum_p1);
`else
    assign w_next_acc_p1 = w_sum_p1[ACC_W-1:0];
`endif

    // Operand capture for each accepted pair; data path carries no reset.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_a_p1 <= $signed(a);
            r_b_p1 <= $signed(b);
        end
    end

    // Job sequencing FSM plus accumulator, valid pipeline and sticky overflow.
    always_ff @(posedge CLK) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_vld_p1 <= 1'b0;
            r_acc_p2 <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;

            if (r_vld_p1) begin
                r_acc_p2 <= w_next_acc_p1;
                if (w_ovf_p1) begin
                    r_ovf <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc_p2 <= $signed(bias);
                        r_ovf    <= 1'b0;
                        r_cnt    <= len;
                        r_state  <= (len != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
